// File: rtl/pdm_rec_ctrl_if.sv
// Sample-memory bus between the record/playback controller and the sample RAM.
// The RAM answers a read with mem_rdata valid exactly one cycle after mem_re.
interface pdm_rec_ctrl_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 7
) ();
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_we,
      output mem_waddr,
      output mem_wdata,
      output mem_re,
      output mem_raddr,
      input  mem_rdata
   );

   modport slave (
      input  mem_we,
      input  mem_waddr,
      input  mem_wdata,
      input  mem_re,
      input  mem_raddr,
      output mem_rdata
   );
endinterface

// File: rtl/pdm_rec_ctrl.sv
// Record/playback controller: captures one memory-full of decimated PDM samples,
// then replays them at a fixed divided rate with an amplifier enable and LED meter.
module pdm_rec_ctrl #(
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 7,
   parameter int PLAY_DIV = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rec_start,
   input  logic              i_play_start,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_sample_data,
   pdm_rec_ctrl_if.master    mem_bus,
   output logic              o_play_valid,
   output logic [DATA_W-1:0] o_play_data,
   output logic              o_amp_en,
   output logic              o_busy,
   output logic [15:0]       o_led,
   output logic [1:0]        o_state
);
   // Handshake: every strobe (start pulses, sample_valid, mem_we, mem_re,
   // play_valid) is a single-cycle qualifier with no backpressure; data beside
   // a strobe is only meaningful in the cycle the strobe is high.

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int DIV_W = $clog2(PLAY_DIV);
   localparam logic [ADDR_W:0]  LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]  FULL      = (ADDR_W+1)'(DEPTH);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PLAY_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REC  = 2'd1,
      ST_PLAY = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_rec_go;
   logic              w_play_go;
   logic              w_rec_last;
   logic              w_div_wrap;

   // r_count is the LED level too: it climbs while recording and is
   // reloaded to DEPTH then counted down per delivered sample while playing.
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   r_rd_idx;
   logic              r_recorded;
   logic [DIV_W-1:0]  r_div;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_re;
   logic [ADDR_W-1:0] r_raddr;
   logic              r_pv;
   logic [DATA_W-1:0] r_play_hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_rec_go   = 1'b0;
      w_play_go  = 1'b0;
      w_rec_last = 1'b0;
      o_busy     = 1'b0;
      o_amp_en   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_rec_start) begin
               w_rec_go = 1'b1;
               w_next   = ST_REC;
            end else if (i_play_start && r_recorded) begin
               w_play_go = 1'b1;
               w_next    = ST_PLAY;
            end
         end
         ST_REC: begin
            o_busy = 1'b1;
            if (i_sample_valid && (r_count == LAST_ADDR)) begin
               w_rec_last = 1'b1;
               w_next     = ST_IDLE;
            end
         end
         ST_PLAY: begin
            o_busy   = 1'b1;
            o_amp_en = 1'b1;
            // The level reaches zero exactly with the strobe for the last address.
            if (r_pv && (r_count == '0)) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign w_div_wrap = (r_div == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= '0;
         r_rd_idx    <= '0;
         r_recorded  <= 1'b0;
         r_div       <= '0;
         r_we        <= 1'b0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_re        <= 1'b0;
         r_raddr     <= '0;
         r_pv        <= 1'b0;
         r_play_hold <= '0;
      end else begin
         r_we <= 1'b0;
         r_re <= 1'b0;
         r_pv <= r_re;
         if (r_pv) begin
            r_play_hold <= mem_bus.mem_rdata;
         end
         if (w_rec_go) begin
            r_count    <= '0;
            r_recorded <= 1'b0;
         end else if (w_play_go) begin
            r_count  <= FULL;
            r_div    <= '0;
            r_re     <= 1'b1;
            r_raddr  <= '0;
            r_rd_idx <= (ADDR_W+1)'(1);
         end else if ((r_state == ST_REC) && i_sample_valid) begin
            r_we    <= 1'b1;
            r_waddr <= r_count[ADDR_W-1:0];
            r_wdata <= i_sample_data;
            r_count <= r_count + 1'b1;
            if (w_rec_last) begin
               r_recorded <= 1'b1;
            end
         end else if (r_state == ST_PLAY) begin
            if (r_re) begin
               r_count <= r_count - 1'b1;
            end
            if (w_div_wrap) begin
               r_div <= '0;
               if (r_rd_idx != FULL) begin
                  r_re     <= 1'b1;
                  r_raddr  <= r_rd_idx[ADDR_W-1:0];
                  r_rd_idx <= r_rd_idx + 1'b1;
               end
            end else begin
               r_div <= r_div + 1'b1;
            end
         end
      end
   end

   // Read data arrives in the strobe cycle itself, so it is passed straight
   // through then and held afterwards.
   assign o_play_valid = r_pv;
   assign o_play_data  = r_pv ? mem_bus.mem_rdata : r_play_hold;

   always_comb begin
      o_led = '0;
      for (int i = 0; i < 16; i++) begin
         o_led[i] = (r_count >= (ADDR_W+1)'((i + 1) * (DEPTH / 16)));
      end
   end

   assign mem_bus.mem_we    = r_we;
   assign mem_bus.mem_waddr = r_waddr;
   assign mem_bus.mem_wdata = r_wdata;
   assign mem_bus.mem_re    = r_re;
   assign mem_bus.mem_raddr = r_raddr;
   assign o_state           = r_state;

endmodule

// File: tb/tb_pdm_rec_ctrl.sv
// Bench for pdm_rec_ctrl at ADDR_W=5 / PLAY_DIV=4: vector table for the start-up
// behaviour, then record/playback sequences checked against a schedule model.
module tb_pdm_rec_ctrl;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 7;
   localparam int PLAY_DIV = 4;
   localparam int DEPTH    = 32;
   localparam int LAST_C   = PLAY_DIV * (DEPTH - 1) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rec_start = 1'b0;
   logic              play_start = 1'b0;
   logic              sample_valid = 1'b0;
   logic [DATA_W-1:0] sample_data = '0;
   logic              play_valid;
   logic [DATA_W-1:0] play_data;
   logic              amp_en;
   logic              busy;
   logic [15:0]       led;
   logic [1:0]        state;

   pdm_rec_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

   pdm_rec_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PLAY_DIV(PLAY_DIV)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_rec_start    (rec_start),
      .i_play_start   (play_start),
      .i_sample_valid (sample_valid),
      .i_sample_data  (sample_data),
      .mem_bus        (mem_bus),
      .o_play_valid   (play_valid),
      .o_play_data    (play_data),
      .o_amp_en       (amp_en),
      .o_busy         (busy),
      .o_led          (led),
      .o_state        (state)
   );

   always #5 clk = ~clk;

   // Sample RAM with one-cycle registered read.
   logic [DATA_W-1:0] mem_arr [DEPTH];
   always @(posedge clk) begin
      if (mem_bus.mem_we) mem_arr[mem_bus.mem_waddr] <= mem_bus.mem_wdata;
      if (mem_bus.mem_re) mem_bus.mem_rdata <= mem_arr[mem_bus.mem_raddr];
   end

   // Bus monitor: logs writes, counts reads and write/read overlaps.
   logic [ADDR_W+DATA_W-1:0] obs_q[$];
   int excl_viol = 0;
   int re_cnt    = 0;
   always @(negedge clk) begin
      if (mem_bus.mem_we && mem_bus.mem_re) excl_viol++;
      if (mem_bus.mem_re) re_cnt++;
      if (mem_bus.mem_we) obs_q.push_back({mem_bus.mem_waddr, mem_bus.mem_wdata});
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   int checks   = 0;
   int failures = 0;
   int obs_i    = 0;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0]        ref_mem [DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Expected LED pattern: one lit segment per full DEPTH/16 of level.
   function automatic logic [15:0] thermo(input int level);
      int n;
      n = level * 16 / DEPTH;
      return 16'((32'h1 << n) - 1);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, state, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_amp_en"}, amp_en, 0);
      check({tag, "_led"}, led, 0);
      check({tag, "_we"}, mem_bus.mem_we, 0);
      check({tag, "_re"}, mem_bus.mem_re, 0);
      check({tag, "_waddr"}, mem_bus.mem_waddr, 0);
      check({tag, "_wdata"}, mem_bus.mem_wdata, 0);
      check({tag, "_raddr"}, mem_bus.mem_raddr, 0);
      check({tag, "_play_valid"}, play_valid, 0);
      check({tag, "_play_data"}, play_data, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; rec_start = 1'b0; play_start = 1'b0; sample_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
   endtask

   task automatic drain_writes(input string tag);
      logic [ADDR_W+DATA_W-1:0] e;
      @(negedge clk);
      while (obs_i < obs_q.size()) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_wr_extra: got write 0x%0h required none", tag, obs_q[obs_i]);
         end else begin
            e = exp_q.pop_front();
            check({tag, "_wr"}, obs_q[obs_i], e);
         end
         obs_i++;
      end
      check({tag, "_wr_missing"}, exp_q.size(), 0);
   endtask

   task automatic pulse_play();
      @(negedge clk) play_start = 1'b1;
      @(negedge clk) play_start = 1'b0;
   endtask

   // 40 strobes after rec_start; only the first DEPTH may be written.
   task automatic run_record(input bit rand_data);
      logic [DATA_W-1:0] d;
      @(negedge clk) rec_start = 1'b1;
      @(negedge clk) rec_start = 1'b0;
      check("rec_enter_state", state, 1);
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         d = rand_data ? DATA_W'($urandom) : DATA_W'(k);
         sample_valid = 1'b1;
         sample_data  = d;
         rec_start    = (k == 10);
         if (k < DEPTH) begin
            exp_q.push_back({ADDR_W'(k), d});
            ref_mem[k] = d;
         end
         @(negedge clk);
         sample_valid = 1'b0;
         rec_start    = 1'b0;
         check($sformatf("rec_we_k%0d", k), mem_bus.mem_we, (k < DEPTH));
         check($sformatf("rec_led_k%0d", k), led, thermo((k < DEPTH) ? k + 1 : DEPTH));
         check($sformatf("rec_busy_k%0d", k), busy, (k < DEPTH - 1));
         if (k == 1) check("rec_led_after_2", led, 16'h0001);
         if (k == DEPTH - 1) check("rec_led_full", led, 16'hFFFF);
      end
      check("rec_done_state", state, 0);
      drain_writes("rec");
      check("rec_idle_led_hold", led, 16'hFFFF);
   endtask

   // Reads every PLAY_DIV cycles from the first PLAY cycle (c=0); each strobe
   // follows its read by one cycle; last strobe at c=LAST_C.
   task automatic run_play();
      int npv;
      bit exp_re, exp_pv;
      int re_base;
      re_base = re_cnt;
      pulse_play();
      for (int c = 0; c <= LAST_C + 3; c++) begin
         play_start = (c == 50);
         exp_re = ((c % PLAY_DIV) == 0) && ((c / PLAY_DIV) < DEPTH);
         exp_pv = (c >= 1) && (((c - 1) % PLAY_DIV) == 0) && (((c - 1) / PLAY_DIV) < DEPTH);
         npv = (c >= 1) ? ((c - 1) / PLAY_DIV + 1) : 0;
         if (npv > DEPTH) npv = DEPTH;
         check($sformatf("play_re_c%0d", c), mem_bus.mem_re, exp_re);
         if (exp_re) check($sformatf("play_raddr_c%0d", c), mem_bus.mem_raddr, c / PLAY_DIV);
         check($sformatf("play_valid_c%0d", c), play_valid, exp_pv);
         if (exp_pv) check($sformatf("play_data_c%0d", c), play_data, ref_mem[(c - 1) / PLAY_DIV]);
         check($sformatf("play_amp_c%0d", c), amp_en, (c <= LAST_C));
         check($sformatf("play_busy_c%0d", c), busy, (c <= LAST_C));
         check($sformatf("play_led_c%0d", c), led, thermo(DEPTH - npv));
         if (c == PLAY_DIV + 1) check("play_led_after_2", led, 16'h7FFF);
         @(negedge clk);
      end
      play_start = 1'b0;
      check("play_end_state", state, 0);
      check("play_data_hold", play_data, ref_mem[DEPTH - 1]);
      check("play_read_count", re_cnt - re_base, DEPTH);
   endtask

   typedef struct {
      bit                rec;
      bit                play;
      bit                sv;
      logic [DATA_W-1:0] data;
      logic [1:0]        st;
      bit                we;
      logic [ADDR_W-1:0] wa;
      logic [15:0]       led;
   } vec_t;

   function automatic vec_t mk(bit rec, bit play, bit sv, logic [DATA_W-1:0] data,
                               logic [1:0] st, bit we, logic [ADDR_W-1:0] wa, logic [15:0] l);
      vec_t v;
      v.rec = rec; v.play = play; v.sv = sv; v.data = data;
      v.st = st; v.we = we; v.wa = wa; v.led = l;
      return v;
   endfunction

   vec_t vecs [9];
   bit   found;
   int   re_base;

   initial begin
      vecs[0] = mk(0, 1, 0, 7'd0,   2'd0, 0, 5'd0, 16'h0000);
      vecs[1] = mk(0, 0, 0, 7'd0,   2'd0, 0, 5'd0, 16'h0000);
      vecs[2] = mk(1, 0, 0, 7'd0,   2'd1, 0, 5'd0, 16'h0000);
      vecs[3] = mk(0, 0, 1, 7'd5,   2'd1, 1, 5'd0, 16'h0000);
      vecs[4] = mk(1, 0, 0, 7'd0,   2'd1, 0, 5'd0, 16'h0000);
      vecs[5] = mk(0, 0, 1, 7'd9,   2'd1, 1, 5'd1, 16'h0001);
      vecs[6] = mk(0, 1, 0, 7'd0,   2'd1, 0, 5'd0, 16'h0001);
      vecs[7] = mk(0, 0, 1, 7'h7F,  2'd1, 1, 5'd2, 16'h0001);
      vecs[8] = mk(0, 0, 1, 7'd1,   2'd1, 1, 5'd3, 16'h0003);

      do_reset();
      for (int i = 0; i < 9; i++) begin
         rec_start    = vecs[i].rec;
         play_start   = vecs[i].play;
         sample_valid = vecs[i].sv;
         sample_data  = vecs[i].data;
         if (vecs[i].we) exp_q.push_back({vecs[i].wa, vecs[i].data});
         @(negedge clk);
         rec_start = 1'b0; play_start = 1'b0; sample_valid = 1'b0;
         check($sformatf("vec%0d_state", i), state, vecs[i].st);
         check($sformatf("vec%0d_busy", i), busy, (vecs[i].st != 2'd0));
         check($sformatf("vec%0d_we", i), mem_bus.mem_we, vecs[i].we);
         if (vecs[i].we) check($sformatf("vec%0d_waddr", i), mem_bus.mem_waddr, vecs[i].wa);
         check($sformatf("vec%0d_led", i), led, vecs[i].led);
      end
      drain_writes("vec");
      check("no_read_before_record", re_cnt, 0);

      do_reset();
      run_record(1'b0);
      run_play();
      run_play();

      @(negedge clk) begin rec_start = 1'b1; play_start = 1'b1; end
      @(negedge clk) begin rec_start = 1'b0; play_start = 1'b0; end
      check("both_start_state", state, 1);
      check("both_start_amp_en", amp_en, 0);
      check("both_start_led", led, 16'h0000);
      run_record(1'b1);
      run_play();

      pulse_play();
      found = 1'b0;
      for (int t = 0; t < 200 && !found; t++) begin
         if (mem_bus.mem_re && (mem_bus.mem_raddr == 5'd10)) found = 1'b1;
         else @(negedge clk);
      end
      check("play_reached_addr10", found, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_mid_play");
      rst = 1'b0;
      re_base = re_cnt;
      pulse_play();
      for (int t = 0; t < 10; t++) begin
         check($sformatf("post_rst_state_t%0d", t), state, 0);
         @(negedge clk);
      end
      check("post_rst_no_read", re_cnt - re_base, 0);
      check("post_rst_no_write", obs_q.size() - obs_i, 0);
      check("we_re_exclusive", excl_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pdm_rec_ctrl.md
PDM_REC_CTRL -- requirements
Module: pdm_rec_ctrl

Interface
REQ-001 Parameter ADDR_W, default 17, sample memory address width; DEPTH = 2**ADDR_W; ADDR_W >= 4.
REQ-002 Parameter DATA_W, default 7, sample width.
REQ-003 Parameter PLAY_DIV, default 1024, clk cycles between playback reads; >= 2.
REQ-004 clk  in  1  system clock (100 MHz); single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rec_start  in  1  one-cycle pulse, already debounced; requests record.
REQ-007 play_start  in  1  one-cycle pulse, already debounced; requests playback.
REQ-008 sample_valid  in  1  one-cycle strobe from the PDM decimator.
REQ-009 sample_data  in  DATA_W  decimated sample; qualified by sample_valid.
REQ-010 mem_we  out  1  memory write enable.
REQ-011 mem_waddr  out  ADDR_W  memory write address.
REQ-012 mem_wdata  out  DATA_W  memory write data.
REQ-013 mem_re  out  1  memory read enable.
REQ-014 mem_raddr  out  ADDR_W  memory read address.
REQ-015 mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re.
REQ-016 play_valid  out  1  one-cycle strobe qualifying play_data.
REQ-017 play_data  out  DATA_W  sample delivered to the PDM/PWM output stage.
REQ-018 amp_en  out  1  audio amplifier shutdown control (AUD_SD); 1 only in PLAY.
REQ-019 busy  out  1  1 in REC or PLAY.
REQ-020 led  out  16  progress thermometer.

Function
REQ-021 States IDLE, REC and PLAY SHALL be the only states.
REQ-022 In IDLE, rec_start SHALL enter REC next cycle with count=0; rec_start has priority when both start inputs are asserted in the same cycle.
REQ-023 In IDLE, play_start SHALL enter PLAY only if the recorded flag is 1; otherwise it SHALL be ignored.
REQ-024 Start pulses received in REC or PLAY SHALL be ignored (no restart, no queuing).
REQ-025 In REC, each sample_valid SHALL produce a registered write one cycle later: mem_we=1, mem_waddr=count, mem_wdata=sample_data; count then increments.
REQ-026 In REC, after the write at address DEPTH-1, the block SHALL return to IDLE, set the recorded flag, and leave count=DEPTH (ADDR_W+1 bits); further sample_valid strobes SHALL cause no write.
REQ-027 In PLAY, a divider SHALL pulse mem_re once every PLAY_DIV cycles, with the first pulse in the first PLAY cycle, and mem_raddr = 0, 1, ..., DEPTH-1 in order.
REQ-028 One cycle after each mem_re, play_valid=1 and play_data=mem_rdata; after the play_valid for address DEPTH-1 the block SHALL return to IDLE in the following cycle.
REQ-029 play_data SHALL hold its last value between strobes and after PLAY ends.
REQ-030 led[i] SHALL be 1 iff level >= (i+1)*DEPTH/16. In REC and after REC, level = count. In PLAY, level = DEPTH minus the number of play_valid strobes issued. After PLAY, level = 0.
REQ-031 After a completed recording, led SHALL hold 16'hFFFF in IDLE until playback starts; the recorded flag stays 1, so repeated playback is allowed.
REQ-032 A new rec_start SHALL clear the recorded flag and overwrite memory from address 0.
REQ-033 mem_we and mem_re SHALL never be asserted in the same cycle.

Reset
REQ-034 While rst=1 (sampled on clk), the block SHALL drive: state=IDLE, count=0, recorded flag=0, divider=0, mem_we=0, mem_re=0, mem_waddr=0, mem_raddr=0, mem_wdata=0, play_valid=0, play_data=0, amp_en=0, busy=0, led=0.
REQ-035 rst asserted mid-REC or mid-PLAY SHALL abort the operation; afterwards, play_start SHALL be ignored until a full recording completes.

Verification (ADDR_W=5, DEPTH=32, PLAY_DIV=4)
REQ-036 Reset, then play_start -> state stays IDLE, mem_re never asserted, led=0.
REQ-037 rec_start, then 40 sample_valid strobes with data=k -> exactly 32 writes, addr k = data k for k=0..31; led=16'h0001 after 2 writes, 16'hFFFF after 32; busy falls; writes 33-40 absent.
REQ-038 play_start after REQ-037 -> mem_re every 4 cycles, addr 0..31; play_valid one cycle after each mem_re with play_data=addr; amp_en=1 throughout PLAY; led=16'h7FFF after 2 strobes, 0 at end.
REQ-039 rec_start and play_start in the same cycle from IDLE with recorded=1 -> REC entered and recorded flag cleared.
REQ-040 rst during PLAY at address 10 -> all outputs at reset values next cycle; subsequent play_start ignored.
REQ-041 rec_start asserted mid-REC and play_start asserted mid-PLAY -> no effect on address sequence or strobe count.
